// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer for two requesters sharing one 32-bit ALU; holds operands for a per-op latency.
// Build option: define ALU_SHARE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties, ptr held at 0).
`timescale 1ns/1ps
module alu_share_arb #(
  parameter int MUL_LAT = 2,
  parameter int OP_LAT  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic [2:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  input  logic [2:0]  req1_ctrl_i,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_zero_o,
  output logic        resp_id_o
);

  localparam logic [2:0] CTRL_MUL = 3'b010;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);
  localparam logic [3:0] OP_CNT   = 4'(OP_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        ptr_q;
  logic [3:0]  cnt_q;
  logic [31:0] op_data1_q;
  logic [31:0] op_data2_q;
  logic [2:0]  op_ctrl_q;
  logic        op_id_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        resp_zero_q;
  logic        resp_id_q;

  logic        win_d;
  logic        grant_d;
  logic [31:0] sel_data1_d;
  logic [31:0] sel_data2_d;
  logic [2:0]  sel_ctrl_d;
  logic [3:0]  sel_cnt_d;
  logic        ptr_d;

  // Grant depends only on state, ptr and this cycle's valids; rst_i masks it so no accept is advertised during reset.
  always_comb begin
    win_d = ptr_q;
    if (ptr_q ? !req1_valid_i : !req0_valid_i) begin
      win_d = ~ptr_q;
    end
    grant_d = (state_q == IDLE) && !rst_i && (win_d ? req1_valid_i : req0_valid_i);
  end

  assign req0_ready_o = grant_d && !win_d;
  assign req1_ready_o = grant_d &&  win_d;

  always_comb begin
    sel_data1_d = win_d ? req1_data1_i : req0_data1_i;
    sel_data2_d = win_d ? req1_data2_i : req0_data2_i;
    sel_ctrl_d  = win_d ? req1_ctrl_i  : req0_ctrl_i;
    sel_cnt_d   = (sel_ctrl_d == CTRL_MUL) ? MUL_CNT : OP_CNT;
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
    ptr_d = 1'b0;
`else
    ptr_d = ~win_d;
`endif
  end

  // Operand registers double as the ALU drive: loaded on accept, cleared when leaving EXEC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      cnt_q        <= 4'd0;
      op_data1_q   <= 32'd0;
      op_data2_q   <= 32'd0;
      op_ctrl_q    <= 3'd0;
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_zero_q  <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            op_data1_q <= sel_data1_d;
            op_data2_q <= sel_data2_d;
            op_ctrl_q  <= sel_ctrl_d;
            op_id_q    <= win_d;
            cnt_q      <= sel_cnt_d;
            ptr_q      <= ptr_d;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            resp_data_q  <= alu_data_i;
            resp_zero_q  <= alu_zero_i;
            resp_id_q    <= op_id_q;
            resp_valid_q <= 1'b1;
            op_data1_q   <= 32'd0;
            op_data2_q   <= 32'd0;
            op_ctrl_q    <= 3'd0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          // Handshake returns to IDLE; the next accept can only happen a cycle later.
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_data1_o  = op_data1_q;
  assign alu_data2_o  = op_data2_q;
  assign alu_ctrl_o   = op_ctrl_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_zero_o  = resp_zero_q;
  assign resp_id_o    = resp_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Randomized bench for alu_share_arb with a transaction-timeline reference model and a behavioural ALU.
`timescale 1ns/1ps
module tb_alu_share_arb;
  localparam int MUL_LAT = 3;
  localparam int OP_LAT  = 1;
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
  } op_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_data1_i = '0, req0_data2_i = '0, req1_data1_i = '0, req1_data2_i = '0;
  logic [2:0]  req0_ctrl_i = '0, req1_ctrl_i = '0;
  logic [31:0] alu_data1_o, alu_data2_o, alu_data_i, resp_data_o;
  logic [2:0]  alu_ctrl_o;
  logic        alu_zero_i, resp_valid_o, resp_zero_o, resp_id_o;
  logic        resp_ready_i = 1'b1;

  always #5 clk_i = ~clk_i;

  alu_share_arb #(.MUL_LAT(MUL_LAT), .OP_LAT(OP_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_zero_o(resp_zero_o), .resp_id_o(resp_id_o)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_data_i = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);
  assign alu_zero_i = (alu_data_i == 32'd0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one op in flight, accepted at cycle m_t0, ALU busy for m_L cycles, then response until taken.
  op_t  q0[$], q1[$];
  int   done_ids[$];
  int   cyc = 0;
  bit   m_have = 0;
  int   m_t0 = 0, m_L = 0;
  op_t  m_op;
  logic m_id = 0, m_ptr = 0;
  int   rr_mode = 0;
  bit   gap_en = 0;

  task automatic step();
    logic e_r0, e_r1, e_rv, pref, win, hit0, hit1;
    logic [31:0] e_a1, e_a2, e_res;
    logic [2:0] e_ac;
    bit any, acc0, acc1;
    @(negedge clk_i);
    e_r0 = 0; e_r1 = 0; e_rv = 0; e_a1 = 0; e_a2 = 0; e_ac = 0; win = 0; any = 0;
    if (rst_i) begin
      chk("rst_ready0", {31'd0, req0_ready_o}, 0);
      chk("rst_ready1", {31'd0, req1_ready_o}, 0);
      m_have = 0;
      m_ptr = 0;
    end else begin
      if (!m_have) begin
        pref = FIXED ? 1'b0 : m_ptr;
        hit0 = pref ? req1_valid_i : req0_valid_i;
        hit1 = pref ? req0_valid_i : req1_valid_i;
        if (hit0) begin win = pref; any = 1; end
        else if (hit1) begin win = ~pref; any = 1; end
        if (any) begin
          if (win) e_r1 = 1; else e_r0 = 1;
          m_have = 1;
          m_t0 = cyc;
          m_id = win;
          m_op = win ? q1[0] : q0[0];
          m_L = (m_op.c == 3'b010) ? MUL_LAT : OP_LAT;
          if (!FIXED) m_ptr = ~win;
        end
      end else if (cyc <= m_t0 + m_L) begin
        e_a1 = m_op.a; e_a2 = m_op.b; e_ac = m_op.c;
      end else begin
        e_rv = 1;
        e_res = alu_fn(m_op.c, m_op.a, m_op.b);
        chk("resp_data", resp_data_o, e_res);
        chk("resp_zero", {31'd0, resp_zero_o}, {31'd0, e_res == 32'd0});
        chk("resp_id", {31'd0, resp_id_o}, {31'd0, m_id});
        if (resp_ready_i) begin
          m_have = 0;
          done_ids.push_back(int'(m_id));
        end
      end
      chk("ready0", {31'd0, req0_ready_o}, {31'd0, e_r0});
      chk("ready1", {31'd0, req1_ready_o}, {31'd0, e_r1});
      chk("alu_data1", alu_data1_o, e_a1);
      chk("alu_data2", alu_data2_o, e_a2);
      chk("alu_ctrl", {29'd0, alu_ctrl_o}, {29'd0, e_ac});
      chk("resp_valid", {31'd0, resp_valid_o}, {31'd0, e_rv});
    end
    acc0 = req0_valid_i && req0_ready_o;
    acc1 = req1_valid_i && req1_ready_o;
    cyc++;
    @(posedge clk_i);
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() == 0) req0_valid_i = 0;
    else if (!req0_valid_i) req0_valid_i = !(gap_en && ($urandom % 3 == 0));
    if (q1.size() == 0) req1_valid_i = 0;
    else if (!req1_valid_i) req1_valid_i = !(gap_en && ($urandom % 3 == 0));
    {req0_data1_i, req0_data2_i, req0_ctrl_i} = (q0.size() > 0) ? q0[0] : '0;
    {req1_data1_i, req1_data2_i, req1_ctrl_i} = (q1.size() > 0) ? q1[0] : '0;
    if (rr_mode == 0) resp_ready_i = 1;
    else if (rr_mode == 1) resp_ready_i = ($urandom % 2 == 0);
  endtask

  task automatic drain(input string tag, input int bound);
    bit busy;
    busy = 1;
    for (int i = 0; i < bound && busy; i++) begin
      busy = (q0.size() != 0) || (q1.size() != 0) || m_have || req0_valid_i || req1_valid_i;
      if (busy) step();
    end
    chk(tag, {31'd0, busy}, 0);
  endtask

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    op_t o;
    o.a = a; o.b = b; o.c = c;
    return o;
  endfunction

  initial begin
    op_t o;
    int n;
    // Reset then idle
    rst_i = 1;
    step(); step();
    rst_i = 0;
    for (int i = 0; i < 3; i++) step();
    chk("idle_resp_data", resp_data_o, 0);
    chk("idle_resp_id", {31'd0, resp_id_o}, 0);

    // Directed: add, mul (MUL_LAT=3), zero-flag sub, pass-through ctrl
    q0.push_back(mk(32'd5, 32'd7, 3'b000));
    drain("drain_add", 20);
    q1.push_back(mk(32'd6, 32'd7, 3'b010));
    drain("drain_mul", 20);
    q0.push_back(mk(32'd9, 32'd9, 3'b001));
    drain("drain_sub", 20);
    q1.push_back(mk(32'h8000_0001, 32'hFFFF_FFFF, 3'b111));
    drain("drain_ctrl7", 20);

    // Backpressure: response held 5 cycles with another op pending
    rr_mode = 2;
    resp_ready_i = 0;
    q0.push_back(mk(32'd100, 32'd23, 3'b010));
    q1.push_back(mk(32'd1, 32'd2, 3'b100));
    for (int i = 0; i < 20 && !resp_valid_o; i++) step();
    chk("bp_resp_seen", {31'd0, resp_valid_o}, 1);
    for (int i = 0; i < 5; i++) step();
    resp_ready_i = 1;
    rr_mode = 0;
    drain("drain_bp", 40);

    // Contention from a fresh reset (ptr=0)
    rst_i = 1; step(); rst_i = 0;
    done_ids.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(32'(i), 32'd10, 3'b000));
      q1.push_back(mk(32'(i), 32'd3, 3'b010));
    end
    drain("drain_contend", 200);
    chk("contend_count", 32'(done_ids.size()), 8);
    n = (done_ids.size() < 8) ? done_ids.size() : 8;
    for (int i = 0; i < n; i++)
      chk("contend_order", 32'(done_ids[i]), FIXED ? ((i < 4) ? 0 : 1) : (i % 2));

    // Reset during mul EXEC: op dropped, req0 wins afterwards since ptr returns to 0
    done_ids.delete();
    q1.push_back(mk(32'd11, 32'd13, 3'b010));
    for (int i = 0; i < 20 && alu_ctrl_o != 3'b010; i++) step();
    chk("mul_exec_seen", {29'd0, alu_ctrl_o}, 32'd2);
    q1.push_back(mk(32'd4, 32'd4, 3'b001));
    q0.push_back(mk(32'd20, 32'd22, 3'b000));
    rst_i = 1; step(); rst_i = 0;
    drain("drain_rst", 40);
    chk("rst_resp_count", 32'(done_ids.size()), 2);
    if (done_ids.size() > 0) chk("rst_first_id", 32'(done_ids[0]), 0);

    // Randomized traffic with gaps and random backpressure
    rr_mode = 1;
    gap_en = 1;
    for (int i = 0; i < 120; i++) begin
      o.a = $urandom;
      o.b = ($urandom % 4 == 0) ? o.a : $urandom;
      o.c = 3'($urandom % 8);
      if ($urandom % 2 == 0) q0.push_back(o); else q1.push_back(o);
      if ($urandom % 8 == 0) begin
        for (int k = 0; k < 1 + int'($urandom % 6); k++) step();
      end
    end
    drain("drain_rand", 4000);
    rr_mode = 0;
    gap_en = 0;
    for (int i = 0; i < 3; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
